// File: rtl/dmem_io.sv
// Data memory and memory-mapped I/O for the single-cycle CPU: word RAM, LED/switch page, compare timer.
// Optional timer block is built only when DMEM_IO_TIMER_EN is defined.
module dmem_io #(
    parameter int DEPTH_LOG2 = 6,
    parameter int SW_W       = 16,
    parameter int LED_W      = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [31:0]      addr,
    input  logic [31:0]      datain,
    input  logic             we,
    output logic [31:0]      dataout,
    input  logic [SW_W-1:0]  sw,
    output logic [LED_W-1:0] led,
    output logic             timer_irq
);

    localparam logic [5:0] SEL_LED  = 6'h00;
    localparam logic [5:0] SEL_SW   = 6'h01;
    localparam logic [5:0] SEL_CTRL = 6'h02;
    localparam logic [5:0] SEL_CMP  = 6'h03;
    localparam logic [5:0] SEL_CNT  = 6'h04;
    localparam logic [5:0] SEL_STAT = 6'h05;

    logic                  ram_hit;
    logic                  per_hit;
    logic                  per_wr;
    logic [5:0]            reg_sel;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic [31:0]           mem [0:(1<<DEPTH_LOG2)-1];
    logic [SW_W-1:0]       sw_meta;
    logic [SW_W-1:0]       sw_sync;
    logic                  unused_bits;

    assign ram_hit = (addr[31:28] == 4'h0);
    assign per_hit = (addr[31:8] == 24'hF00000);
    assign per_wr  = we && per_hit;
    assign reg_sel = addr[7:2];
    assign ram_idx = addr[DEPTH_LOG2+1:2];
    assign unused_bits = ^{addr[1:0], datain};

    // RAM is deliberately outside the reset domain so a CPU reset keeps data.
    always_ff @(posedge clk) begin
        if (we && ram_hit) begin
            mem[ram_idx] <= datain;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            led <= '0;
        end else if (per_wr && (reg_sel == SEL_LED)) begin
            led <= datain[LED_W-1:0];
        end
    end

`ifdef DMEM_IO_TIMER_EN
    logic        ctrl_en;
    logic        ctrl_auto;
    logic        ctrl_irqen;
    logic [31:0] cmp;
    logic [31:0] cnt;
    logic        match;
    logic        hit;

    assign hit = ctrl_en && (cnt == cmp);

    // Later assignments override earlier ones: a CPU CTRL write beats the
    // one-shot auto-disable, and a match set beats a STAT clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            ctrl_en    <= 1'b0;
            ctrl_auto  <= 1'b0;
            ctrl_irqen <= 1'b0;
            cmp        <= 32'hFFFF_FFFF;
            cnt        <= '0;
            match      <= 1'b0;
        end else begin
            if (ctrl_en) begin
                if (cnt == cmp) begin
                    if (ctrl_auto) begin
                        cnt <= '0;
                    end else begin
                        ctrl_en <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + 32'd1;
                end
            end
            if (per_wr && (reg_sel == SEL_CTRL)) begin
                ctrl_en    <= datain[0];
                ctrl_auto  <= datain[1];
                ctrl_irqen <= datain[2];
            end
            if (per_wr && (reg_sel == SEL_CMP)) begin
                cmp <= datain;
            end
            if (hit) begin
                match <= 1'b1;
            end else if (per_wr && (reg_sel == SEL_STAT) && datain[0]) begin
                match <= 1'b0;
            end
        end
    end

    assign timer_irq = match & ctrl_irqen;
`else
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        dataout = '0;
        if (ram_hit) begin
            dataout = mem[ram_idx];
        end else if (per_hit) begin
            case (reg_sel)
                SEL_LED:  dataout = 32'(led);
                SEL_SW:   dataout = 32'(sw_sync);
`ifdef DMEM_IO_TIMER_EN
                SEL_CTRL: dataout = {29'd0, ctrl_irqen, ctrl_auto, ctrl_en};
                SEL_CMP:  dataout = cmp;
                SEL_CNT:  dataout = cnt;
                SEL_STAT: dataout = {31'd0, match};
`endif
                default:  dataout = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_io.sv
// Directed self-checking bench for dmem_io; timer checks follow DMEM_IO_TIMER_EN.
module tb_dmem_io;

    localparam logic [31:0] A_LED  = 32'hF000_0000;
    localparam logic [31:0] A_SW   = 32'hF000_0004;
    localparam logic [31:0] A_CTRL = 32'hF000_0008;
    localparam logic [31:0] A_CMP  = 32'hF000_000C;
    localparam logic [31:0] A_CNT  = 32'hF000_0010;
    localparam logic [31:0] A_STAT = 32'hF000_0014;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        we;
    logic [31:0] dataout;
    logic [15:0] sw;
    logic [15:0] led;
    logic        timer_irq;

    int checks = 0;
    int errors = 0;

    dmem_io #(.DEPTH_LOG2(6), .SW_W(16), .LED_W(16)) dut (
        .clk(clk), .clr(clr), .addr(addr), .datain(datain), .we(we),
        .dataout(dataout), .sw(sw), .led(led), .timer_irq(timer_irq)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        datain = d;
        we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        we = 1'b0;
        #1;
        chk(tag, dataout, exp);
    endtask

    initial begin
        clr = 1'b1; addr = '0; datain = '0; we = 1'b0; sw = '0;
        tick();
        tick();
        @(negedge clk);
        clr = 1'b0;
        chk("rst_led_port", 32'(led), 32'h0);
        chk("rst_irq", 32'(timer_irq), 32'h0);
        rd("rst_led_rd", A_LED, 32'h0);
        rd("rst_sw_rd", A_SW, 32'h0);

        // RAM, aliasing, unmapped region
        wr(32'h0000_0014, 32'h1111_1111);
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
        rd("ram_alias", 32'h0000_0110, 32'hDEAD_BEEF);
        rd("ram_neighbour", 32'h0000_0014, 32'h1111_1111);
        wr(32'h2000_0010, 32'h0000_0000);
        rd("unmapped_rd", 32'h2000_0010, 32'h0);
        rd("unmapped_wr_ignored", 32'h0000_0010, 32'hDEAD_BEEF);
        rd("page_miss", 32'hF000_0100, 32'h0);

        // read during a write returns the old word
        wr(32'h0000_0018, 32'hAAAA_AAAA);
        @(negedge clk);
        addr = 32'h0000_0018; datain = 32'h5555_5555; we = 1'b1;
        #1;
        chk("ram_old_on_write", dataout, 32'hAAAA_AAAA);
        tick();
        we = 1'b0;
        rd("ram_new_after", 32'h0000_0018, 32'h5555_5555);

        // LED and switch sync
        wr(A_LED, 32'h1234_A5A5);
        chk("led_port", 32'(led), 32'h0000_A5A5);
        rd("led_rd", A_LED, 32'h0000_A5A5);
        rd("unlisted_off", 32'hF000_0018, 32'h0);
        @(negedge clk);
        sw = 16'h00F0;
        tick();
        rd("sw_one_edge", A_SW, 32'h0);
        tick();
        rd("sw_two_edges", A_SW, 32'h0000_00F0);

`ifdef DMEM_IO_TIMER_EN
        // auto-reload
        wr(A_CMP, 32'd3);
        rd("cmp_rd", A_CMP, 32'd3);
        wr(A_CTRL, 32'h7);
        rd("ctrl_rd", A_CTRL, 32'h7);
        rd("cnt0", A_CNT, 32'd0);
        tick(); rd("cnt1", A_CNT, 32'd1);
        tick(); rd("cnt2", A_CNT, 32'd2);
        tick(); rd("cnt3", A_CNT, 32'd3);
        rd("match_pre", A_STAT, 32'd0);
        tick(); rd("cnt_reload", A_CNT, 32'd0);
        rd("match_set", A_STAT, 32'd1);
        chk("irq_set", 32'(timer_irq), 32'd1);
        tick();
        wr(A_STAT, 32'h1);
        rd("match_cleared", A_STAT, 32'd0);
        chk("irq_cleared", 32'(timer_irq), 32'd0);
        rd("cnt_after_clear", A_CNT, 32'd2);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        rd("rst1_cnt", A_CNT, 32'd0);
        rd("rst1_ctrl", A_CTRL, 32'd0);

        // one-shot
        wr(A_CMP, 32'd2);
        wr(A_CTRL, 32'h1);
        tick(); tick(); tick();
        rd("oneshot_ctrl", A_CTRL, 32'd0);
        rd("oneshot_cnt", A_CNT, 32'd2);
        rd("oneshot_match", A_STAT, 32'd1);
        chk("oneshot_noirq", 32'(timer_irq), 32'd0);
        tick();
        rd("oneshot_hold", A_CNT, 32'd2);

        // collisions
        wr(A_STAT, 32'h1);
        rd("stat_clr_idle", A_STAT, 32'd0);
        wr(A_STAT, 32'h0);
        wr(A_CTRL, 32'h1);
        wr(A_STAT, 32'h1);
        rd("set_beats_clear", A_STAT, 32'd1);
        rd("disable_on_match", A_CTRL, 32'd0);
        wr(A_CTRL, 32'h1);
        wr(A_CTRL, 32'h5);
        rd("cpu_beats_disable", A_CTRL, 32'h5);
        chk("irq_collision", 32'(timer_irq), 32'd1);
        wr(A_CTRL, 32'h0);
        chk("irq_irqen_off", 32'(timer_irq), 32'd0);
        rd("match_held", A_STAT, 32'd1);
        wr(A_CNT, 32'h55);
        rd("cnt_ro", A_CNT, 32'd2);
        wr(A_CMP, 32'd100);
        wr(A_CTRL, 32'h7);
        tick();
        rd("cnt_running", A_CNT, 32'd3);
        chk("irq_before_rst", 32'(timer_irq), 32'd1);
`else
        wr(A_CTRL, 32'h7);
        rd("noimpl_ctrl", A_CTRL, 32'h0);
        rd("noimpl_cmp", A_CMP, 32'h0);
        tick(); tick();
        chk("noimpl_irq", 32'(timer_irq), 32'd0);
        rd("noimpl_stat", A_STAT, 32'h0);
        rd("noimpl_cnt", A_CNT, 32'h0);
`endif

        // reset mid-run
        wr(A_LED, 32'h0000_00FF);
        chk("led_before_rst", 32'(led), 32'h0000_00FF);
        @(negedge clk);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_irq2", 32'(timer_irq), 32'h0);
        rd("rst_sw_sync", A_SW, 32'h0);
        rd("rst_ram_intact", 32'h0000_0010, 32'hDEAD_BEEF);
`ifdef DMEM_IO_TIMER_EN
        rd("rst_cmp", A_CMP, 32'hFFFF_FFFF);
        rd("rst_cnt", A_CNT, 32'h0);
        rd("rst_ctrl", A_CTRL, 32'h0);
        rd("rst_stat", A_STAT, 32'h0);
        tick();
        rd("rst_cnt_idle", A_CNT, 32'h0);
`else
        rd("rst_cmp_noimpl", A_CMP, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
